// File: rtl/fft_pkg.sv
// Shared widths, FSM encoding and address-generation helpers for the FFT sequencer.
package fft_pkg;

    localparam int FFT_MAX_LOG2   = 9;
    localparam int FFT_MIN_LOG2   = 3;
    localparam int FFT_PIPE_DELAY = 10;

    localparam int ADDR_W = FFT_MAX_LOG2;
    localparam int TW_W   = FFT_MAX_LOG2 - 1;
    localparam int STG_W  = $clog2(FFT_MAX_LOG2);
    localparam int LOG_W  = $clog2(FFT_MAX_LOG2 + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Rotate left by one within the low l bits; bits at l and above come out zero.
    function automatic logic [ADDR_W-1:0] rotl1(input logic [ADDR_W-1:0] a,
                                                input logic [LOG_W-1:0]  l);
        logic [ADDR_W-1:0] r;
        r    = '0;
        r[0] = a[l - 1'b1];
        for (int i = 1; i < ADDR_W; i++) begin
            if (i < int'(l)) r[i] = a[i-1];
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] rotl_L(input logic [ADDR_W-1:0] a,
                                                 input logic [STG_W-1:0]  s,
                                                 input logic [LOG_W-1:0]  l);
        logic [ADDR_W-1:0] r;
        r = a;
        for (int k = 0; k < ADDR_W - 1; k++) begin
            if (k < int'(s)) r = rotl1(r, l);
        end
        return r;
    endfunction

    // (l-1)-bit field with its top s bits set, right-aligned in TW_W bits.
    function automatic logic [TW_W-1:0] tw_mask(input logic [STG_W-1:0] s,
                                               input logic [LOG_W-1:0] l);
        logic [TW_W-1:0] m;
        m = '0;
        for (int i = 0; i < TW_W; i++) begin
            if ((i < int'(l) - 1) && (i >= int'(l) - 1 - int'(s))) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fft_sequencer_delay_line.sv
// Fixed-length shift register with async reset and synchronous flush.
// Latency: CYCLES clocks from din to dout.
// Backpressure: none; shifts every cycle, flush zeroes every stage at once.
module delay_line #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CYCLES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CYCLES; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < CYCLES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CYCLES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CYCLES-1];

endmodule

// File: rtl/fft_sequencer.sv
// Read/write address, twiddle and write-enable sequencer for an in-place constant-geometry radix-2 FFT.
// Latency: reads follow an accepted start by one cycle; writes trail reads by PIPELINE_DELAY; done after L*(N/2+PIPELINE_DELAY).
// Backpressure: none; one butterfly per RUN cycle, abort is the only way to stop early.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int MAX_LOG2       = FFT_MAX_LOG2,
    parameter int MIN_LOG2       = FFT_MIN_LOG2,
    parameter int PIPELINE_DELAY = FFT_PIPE_DELAY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_LOG2+1)-1:0] log2n,
    input  logic                          inverse,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic [$clog2(MAX_LOG2)-1:0]   stage,
    output logic                          rd_bank,
    output logic [MAX_LOG2-1:0]           rd_addr_a,
    output logic [MAX_LOG2-1:0]           rd_addr_b,
    output logic [MAX_LOG2-1:0]           wr_addr_a,
    output logic [MAX_LOG2-1:0]           wr_addr_b,
    output logic                          we,
    output logic [MAX_LOG2-2:0]           tw_addr,
    output logic                          tw_conj,
    output logic                          result_bank
);

    localparam int AW = MAX_LOG2;
    localparam int JW = MAX_LOG2 - 1;
    localparam int SW = $clog2(MAX_LOG2);
    localparam int LW = $clog2(MAX_LOG2 + 1);
    localparam int CW = (PIPELINE_DELAY > 2) ? $clog2(PIPELINE_DELAY) : 1;
    localparam int DW = 1 + 2 * AW;

    localparam logic [LW-1:0] L_MIN     = LW'(MIN_LOG2);
    localparam logic [LW-1:0] L_MAX     = LW'(MAX_LOG2);
    localparam logic [CW-1:0] DRAIN_END = CW'(PIPELINE_DELAY - 1);

    state_t          state, state_n;
    logic [JW-1:0]   j, j_n, last_j;
    logic [SW-1:0]   s, s_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [LW-1:0]   lq, lq_n;
    logic            inv, inv_n;
    logic            res_vld, res_vld_n;
    logic            accept, reject, last_wr, flush;
    logic            rd_vld, run_n;
    logic [AW-1:0]   rd_a_n, rd_b_n;
    logic [JW-1:0]   tw_n;
    logic            conj_n;
    logic [DW-1:0]   wr_bus;

    assign last_j = JW'((AW'(1) << (lq - 1'b1)) - 1'b1);

    // State register; read-side outputs are registered from next-state values so they line up with RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            j         <= '0;
            s         <= '0;
            cnt       <= '0;
            lq        <= L_MIN;
            inv       <= 1'b0;
            res_vld   <= 1'b0;
            cfg_err   <= 1'b0;
            rd_vld    <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            tw_conj   <= 1'b0;
        end else begin
            state     <= state_n;
            j         <= j_n;
            s         <= s_n;
            cnt       <= cnt_n;
            lq        <= lq_n;
            inv       <= inv_n;
            res_vld   <= res_vld_n;
            cfg_err   <= reject;
            rd_vld    <= run_n;
            rd_addr_a <= rd_a_n;
            rd_addr_b <= rd_b_n;
            tw_addr   <= tw_n;
            tw_conj   <= conj_n;
        end
    end

    always_comb begin
        state_n = state;
        j_n     = j;
        s_n     = s;
        cnt_n   = cnt;
        lq_n    = lq;
        inv_n   = inv;
        accept  = 1'b0;
        reject  = 1'b0;
        last_wr = 1'b0;
        flush   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ((log2n >= L_MIN) && (log2n <= L_MAX)) begin
                        accept  = 1'b1;
                        state_n = ST_RUN;
                        j_n     = '0;
                        s_n     = '0;
                        cnt_n   = '0;
                        lq_n    = log2n;
                        inv_n   = inverse;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    flush   = 1'b1;
                end else if (j == last_j) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else begin
                    j_n = j + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    flush   = 1'b1;
                end else if (cnt == DRAIN_END) begin
                    if (s == SW'(lq - 1'b1)) begin
                        state_n = ST_IDLE;
                        last_wr = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                        s_n     = s + 1'b1;
                        j_n     = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        done        = last_wr;
        rd_bank     = s[0];
        result_bank = lq[0] & (res_vld | last_wr);
        run_n       = (state_n == ST_RUN);
        rd_a_n      = '0;
        rd_b_n      = '0;
        tw_n        = '0;
        conj_n      = 1'b0;
        if (run_n) begin
            rd_a_n = rotl_L({j_n, 1'b0}, s_n, lq_n);
            rd_b_n = rotl_L({j_n, 1'b1}, s_n, lq_n);
            tw_n   = (j_n & tw_mask(s_n, lq_n)) << (LW'(AW) - lq_n);
            conj_n = inv_n;
        end
        // The final bank stays valid until another transform is accepted or this one is aborted.
        if (accept || flush) res_vld_n = 1'b0;
        else if (last_wr)    res_vld_n = 1'b1;
        else                 res_vld_n = res_vld;
    end

    assign stage = s;

    delay_line #(
        .WIDTH  (DW),
        .CYCLES (PIPELINE_DELAY)
    ) u_wr_dly (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .din   ({rd_vld, rd_addr_a, rd_addr_b}),
        .dout  (wr_bus)
    );

    assign {we, wr_addr_a, wr_addr_b} = wr_bus;

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomised bench for fft_sequencer against a cycle-indexed trace model built from the address/twiddle rules.
module tb_fft_sequencer;

    localparam int PD   = 10;
    localparam int MAXT = 2500;

    logic       clk = 1'b0;
    logic       rst, start, inverse, abort;
    logic [3:0] log2n;
    logic       busy, done, cfg_err, rd_bank, we, tw_conj, result_bank;
    logic [3:0] stage;
    logic [8:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [7:0] tw_addr;
    logic [54:0] all_out;

    int checks = 0;
    int errors = 0;

    bit e_rd [MAXT];
    bit e_last [MAXT];
    bit e_we [MAXT];
    int e_ra [MAXT];
    int e_rb [MAXT];
    int e_tw [MAXT];
    int e_st [MAXT];
    int e_wa [MAXT];
    int e_wb [MAXT];

    always #5 clk = ~clk;

    fft_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .log2n       (log2n),
        .inverse     (inverse),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .stage       (stage),
        .rd_bank     (rd_bank),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .wr_addr_a   (wr_addr_a),
        .wr_addr_b   (wr_addr_b),
        .we          (we),
        .tw_addr     (tw_addr),
        .tw_conj     (tw_conj),
        .result_bank (result_bank)
    );

    assign all_out = {busy, done, cfg_err, stage, rd_bank, rd_addr_a, rd_addr_b,
                      wr_addr_a, wr_addr_b, we, tw_addr, tw_conj, result_bank};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle trace, cycle 0 being the one in which start is presented.
    task automatic build_model(input int l);
        int n, half, per, t, a, b, ra, rb, mask;
        n    = 1 << l;
        half = n / 2;
        per  = half + PD;
        for (int i = 0; i < MAXT; i++) begin
            e_rd[i] = 0; e_last[i] = 0; e_we[i] = 0;
            e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0; e_st[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
        end
        for (int s = 0; s < l; s++) begin
            mask = ((1 << s) - 1) << (l - 1 - s);
            for (int jj = 0; jj < half; jj++) begin
                t  = 1 + s * per + jj;
                a  = 2 * jj;
                b  = 2 * jj + 1;
                ra = ((a << s) | (a >> (l - s))) & (n - 1);
                rb = ((b << s) | (b >> (l - s))) & (n - 1);
                e_rd[t]   = 1;
                e_last[t] = (jj == half - 1);
                e_ra[t]   = ra;
                e_rb[t]   = rb;
                e_tw[t]   = (jj & mask) << (9 - l);
                e_st[t]   = s;
                e_we[t + PD] = 1;
                e_wa[t + PD] = ra;
                e_wb[t + PD] = rb;
            end
        end
    endtask

    task automatic run_xfm(input int l, input bit iv, input int abort_at, input int rst_at,
                           input bit poke, input bit co_abort);
        int n, total, dup;
        logic [511:0] seen;
        n     = 1 << l;
        total = l * (n / 2 + PD);
        seen  = '0;
        dup   = 0;
        build_model(l);
        for (int t = 0; t <= total + 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (t == 0) begin
                start   = 1'b1;
                log2n   = 4'(l);
                inverse = iv;
                abort   = co_abort;
            end else if (poke && t <= total && (abort_at < 0 || t < abort_at)
                         && $urandom_range(0, 5) == 0) begin
                start   = 1'b1;
                log2n   = 4'($urandom_range(0, 15));
                inverse = 1'($urandom_range(0, 1));
            end
            if (t == abort_at) abort = 1'b1;
            if (t == rst_at) rst = 1'b1;
            #1;
            if (t == rst_at) begin
                chk("rst_async", 64'(all_out), 64'd0);
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                return;
            end
            if (t == 0) begin
                chk("pre_idle", {busy, we, done}, 3'b000);
            end else if (abort_at > 0 && t > abort_at) begin
                chk("post_abort", {busy, we, done}, 3'b000);
                if (t == abort_at + 4) return;
            end else if (t <= total) begin
                chk("done", done, 64'(t == total));
                chk("cfg_quiet", cfg_err, 0);
                chk("we", we, 64'(e_we[t]));
                if (e_we[t]) chk("wr", {wr_addr_a, wr_addr_b}, {9'(e_wa[t]), 9'(e_wb[t])});
                if (e_rd[t]) begin
                    chk("rd", {rd_addr_a, rd_addr_b}, {9'(e_ra[t]), 9'(e_rb[t])});
                    chk("tw", {tw_addr, tw_conj}, {8'(e_tw[t]), iv});
                    chk("stage", {busy, stage, rd_bank}, {1'b1, 4'(e_st[t]), 1'(e_st[t] & 1)});
                    if (seen[rd_addr_a]) dup++;
                    seen[rd_addr_a] = 1'b1;
                    if (seen[rd_addr_b]) dup++;
                    seen[rd_addr_b] = 1'b1;
                    if (e_last[t]) begin
                        chk("cover", $countones(seen), n);
                        chk("cover_dup", dup, 0);
                        seen = '0;
                        dup  = 0;
                    end
                end
                if (t == total) chk("res_bank", result_bank, 64'(l & 1));
            end else begin
                chk("end_idle", {busy, we, done}, 3'b000);
                chk("res_hold", result_bank, 64'(l & 1));
                return;
            end
        end
    endtask

    task automatic bad_start(input int l);
        int ce, bz, w;
        ce = 0; bz = 0; w = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = (k == 0);
            log2n = 4'(l);
            abort = 1'b0;
            #1;
            ce += int'(cfg_err);
            bz += int'(busy);
            w  += int'(we);
        end
        chk("cfg_err", ce, 1);
        chk("cfg_busy", bz, 0);
        chk("cfg_we", w, 0);
    endtask

    initial begin
        int l, n, per, total, kind, ab, rs, sr, bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; inverse = 1'b0; log2n = '0;
        #2;
        chk("reset", 64'(all_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_xfm(3, 1'b0, -1, -1, 1'b0, 1'b0);
        run_xfm(9, 1'b1, -1, -1, 1'b0, 1'b0);
        bad_start(2);
        bad_start(10);
        run_xfm(5, 1'b0, 29, -1, 1'b1, 1'b0);
        run_xfm(4, 1'b0, -1, -1, 1'b0, 1'b1);
        run_xfm(4, 1'b1, -1, 1 + 8 + 4, 1'b1, 1'b0);

        for (int it = 0; it < 14; it++) begin
            l     = $urandom_range(3, 6);
            n     = 1 << l;
            per   = n / 2 + PD;
            total = l * per;
            kind  = $urandom_range(0, 3);
            ab    = -1;
            rs    = -1;
            if (kind == 1) begin
                ab = $urandom_range(1, total - 1);
            end else if (kind == 2) begin
                sr = $urandom_range(0, l - 1);
                rs = 1 + sr * per + n / 2 + $urandom_range(0, PD - 1);
            end
            run_xfm(l, 1'($urandom_range(0, 1)), ab, rs, 1'b1, 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 4; k++) begin
            bad = $urandom_range(0, 8);
            bad_start((bad < 3) ? bad : bad + 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
